// File: rtl/des_key_sched_dir.sv
// des_key_sched_dir
// DES round-key generator. A 64-bit key is loaded through PC-1 into the
// 28-bit halves C and D. Sixteen 48-bit round keys PC-2(C||D) are then
// streamed out over a valid/ready handshake.
//
// DIR = 1 (default): decryption order K16..K1, circular right rotation.
// DIR = 0          : encryption order K1..K16, circular left rotation.
//
// Optional feature macro: KS_ZEROIZE_EN
//   defined   -> C and D are cleared on the 16th transfer, so k reads 0 in IDLE.
//   undefined -> C and D keep the last-round state while IDLE.
// Handshake timing is the same either way.

module des_key_sched_dir #(
    parameter int DIR = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic [63:0] key,
    output logic        busy,
    output logic [47:0] k,
    output logic        k_valid,
    input  logic        k_ready
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // PC-1: DES bit positions (1 = MSB of key) selected for C (first 28)
    // followed by D (last 28).
    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    // PC-2: positions within C||D (1 = MSB of C) forming the 48-bit round key.
    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    state_t      state;
    state_t      next_state;
    logic [3:0]  rnd;
    logic [3:0]  next_rnd;
    logic [27:0] c;
    logic [27:0] d;
    logic [27:0] next_c;
    logic [27:0] next_d;
    logic [55:0] load_cd;

    // Permuted choice 1: 64-bit key -> 56-bit C||D. Parity bits drop out.
    function automatic logic [55:0] pc1(input logic [63:0] kin);
        logic [55:0] r;
        r = '0;
        for (int i = 0; i < 56; i++) begin
            r[6'(55 - i)] = kin[6'(64 - PC1[i])];
        end
        return r;
    endfunction

    // Permuted choice 2: 56-bit C||D -> 48-bit round key.
    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] r;
        r = '0;
        for (int i = 0; i < 48; i++) begin
            r[6'(47 - i)] = cd[6'(56 - PC2[i])];
        end
        return r;
    endfunction

    // Rotation applied before output n. Both orders share the table except
    // at n = 0: encryption rotates by 1 at load, decryption emits C0/D0
    // unchanged because the full left rotation over 16 rounds is 28.
    function automatic logic [1:0] rot_amt(input logic [3:0] n);
        logic [1:0] amt;
        case (n)
            4'd0:              amt = (DIR != 0) ? 2'd0 : 2'd1;
            4'd1, 4'd8, 4'd15: amt = 2'd1;
            default:           amt = 2'd2;
        endcase
        return amt;
    endfunction

    // Circular rotate of one 28-bit half; direction fixed by DIR.
    function automatic logic [27:0] rot28(input logic [27:0] x, input logic [1:0] amt);
        logic [27:0] r;
        r = x;
        if (DIR != 0) begin
            case (amt)
                2'd1:    r = {x[0], x[27:1]};
                2'd2:    r = {x[1:0], x[27:2]};
                default: r = x;
            endcase
        end else begin
            case (amt)
                2'd1:    r = {x[26:0], x[27]};
                2'd2:    r = {x[25:0], x[27:26]};
                default: r = x;
            endcase
        end
        return r;
    endfunction

    // State, round counter and key halves; reset clears everything so k = 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            rnd   <= 4'd0;
            c     <= 28'd0;
            d     <= 28'd0;
        end else begin
            state <= next_state;
            rnd   <= next_rnd;
            c     <= next_c;
            d     <= next_d;
        end
    end

    // Next-state logic: load on req in IDLE, advance one round per transfer.
    always_comb begin
        next_state = state;
        next_rnd   = rnd;
        next_c     = c;
        next_d     = d;
        load_cd    = pc1(key);
        case (state)
            IDLE: begin
                if (req) begin
                    next_c     = rot28(load_cd[55:28], rot_amt(4'd0));
                    next_d     = rot28(load_cd[27:0], rot_amt(4'd0));
                    next_rnd   = 4'd0;
                    next_state = RUN;
                end
            end
            RUN: begin
                if (k_ready) begin
                    if (rnd == 4'd15) begin
                        next_state = IDLE;
                        next_rnd   = 4'd0;
`ifdef KS_ZEROIZE_EN
                        next_c     = 28'd0;
                        next_d     = 28'd0;
`else
                        next_c     = c;
                        next_d     = d;
`endif
                    end else begin
                        next_rnd = rnd + 4'd1;
                        next_c   = rot28(c, rot_amt(rnd + 4'd1));
                        next_d   = rot28(d, rot_amt(rnd + 4'd1));
                    end
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign busy    = (state == RUN);
    assign k_valid = (state == RUN);
    assign k       = pc2({c, d});

endmodule

// File: tb/tb_des_key_sched_dir.sv
// Directed testbench for des_key_sched_dir. One instance per key order
// (DIR=1 decrypt, DIR=0 encrypt) sharing clock and reset.

module tb_des_key_sched_dir;

    localparam logic [63:0] KEY = 64'h133457799BBCDFF1;

    // Round keys K1..K16 of the reference key, index 0 = K1.
    localparam logic [47:0] K_TAB [16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };

    logic        clk;
    logic        rst_n;

    logic        req1;
    logic [63:0] key1;
    logic        busy1;
    logic [47:0] k1;
    logic        k_valid1;
    logic        k_ready1;

    logic        req0;
    logic [63:0] key0;
    logic        busy0;
    logic [47:0] k0;
    logic        k_valid0;
    logic        k_ready0;

    int vectors;
    int miscompares;

    des_key_sched_dir #(.DIR(1)) dut_dec (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req1),
        .key     (key1),
        .busy    (busy1),
        .k       (k1),
        .k_valid (k_valid1),
        .k_ready (k_ready1)
    );

    des_key_sched_dir #(.DIR(0)) dut_enc (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req0),
        .key     (key0),
        .busy    (busy0),
        .k       (k0),
        .k_valid (k_valid0),
        .k_ready (k_ready0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected idle k after a completed run.
    function automatic logic [47:0] idle_k(input logic dec);
`ifdef KS_ZEROIZE_EN
        idle_k = 48'h0;
`else
        idle_k = dec ? K_TAB[0] : K_TAB[15];
`endif
    endfunction

    task automatic start_dec(input logic [63:0] kv);
        key1 = kv; req1 = 1'b1; k_ready1 = 1'b1;
        @(posedge clk); #1;
        req1 = 1'b0;
    endtask

    task automatic start_enc(input logic [63:0] kv);
        key0 = kv; req0 = 1'b1; k_ready0 = 1'b1;
        @(posedge clk); #1;
        req0 = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        req1 = 1'b0; key1 = '0; k_ready1 = 1'b0;
        req0 = 1'b0; key0 = '0; k_ready0 = 1'b0;
        #12;
        vectors++; if (busy1 !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy1 got %b expected 0", busy1); end
        vectors++; if (k_valid1 !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_kvalid1 got %b expected 0", k_valid1); end
        vectors++; if (k1 !== 48'h0) begin miscompares++; $display("[TB] FAIL reset_k1 got %h expected 0", k1); end
        vectors++; if (busy0 !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy0 got %b expected 0", busy0); end
        vectors++; if (k_valid0 !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_kvalid0 got %b expected 0", k_valid0); end
        vectors++; if (k0 !== 48'h0) begin miscompares++; $display("[TB] FAIL reset_k0 got %h expected 0", k0); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_decrypt_order;
        start_dec(KEY);
        for (int i = 0; i < 16; i++) begin
            vectors++; if (k1 !== K_TAB[15 - i]) begin miscompares++; $display("[TB] FAIL dec_k[%0d] got %h expected %h", i, k1, K_TAB[15 - i]); end
            vectors++; if (k_valid1 !== 1'b1 || busy1 !== 1'b1) begin miscompares++; $display("[TB] FAIL dec_valid[%0d] got %b/%b expected 1/1", i, k_valid1, busy1); end
            @(posedge clk); #1;
        end
        vectors++; if (busy1 !== 1'b0 || k_valid1 !== 1'b0) begin miscompares++; $display("[TB] FAIL dec_end got %b/%b expected 0/0", busy1, k_valid1); end
        vectors++; if (k1 !== idle_k(1'b1)) begin miscompares++; $display("[TB] FAIL dec_idle_k got %h expected %h", k1, idle_k(1'b1)); end
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (k_valid1 !== 1'b0 || k1 !== idle_k(1'b1)) begin miscompares++; $display("[TB] FAIL dec_idle_ready got %b/%h expected 0/%h", k_valid1, k1, idle_k(1'b1)); end
    endtask

    task automatic test_encrypt_order;
        start_enc(KEY);
        for (int i = 0; i < 16; i++) begin
            vectors++; if (k0 !== K_TAB[i]) begin miscompares++; $display("[TB] FAIL enc_k[%0d] got %h expected %h", i, k0, K_TAB[i]); end
            vectors++; if (k_valid0 !== 1'b1) begin miscompares++; $display("[TB] FAIL enc_valid[%0d] got %b expected 1", i, k_valid0); end
            @(posedge clk); #1;
        end
        vectors++; if (busy0 !== 1'b0 || k_valid0 !== 1'b0) begin miscompares++; $display("[TB] FAIL enc_end got %b/%b expected 0/0", busy0, k_valid0); end
        vectors++; if (k0 !== idle_k(1'b0)) begin miscompares++; $display("[TB] FAIL enc_idle_k got %h expected %h", k0, idle_k(1'b0)); end
    endtask

    task automatic test_stall;
        int transfers;
        transfers = 0;
        start_dec(KEY);
        for (int i = 0; i < 16; i++) begin
            vectors++; if (k1 !== K_TAB[15 - i]) begin miscompares++; $display("[TB] FAIL stall_k[%0d] got %h expected %h", i, k1, K_TAB[15 - i]); end
            if (i == 3) begin
                k_ready1 = 1'b0;
                repeat (5) begin
                    @(posedge clk); #1;
                    vectors++; if (k1 !== K_TAB[12] || k_valid1 !== 1'b1) begin miscompares++; $display("[TB] FAIL stall_hold got %h/%b expected %h/1", k1, k_valid1, K_TAB[12]); end
                end
                k_ready1 = 1'b1;
            end
            if (k_valid1 === 1'b1) transfers++;
            @(posedge clk); #1;
        end
        vectors++; if (transfers !== 16) begin miscompares++; $display("[TB] FAIL stall_count got %0d expected 16", transfers); end
        vectors++; if (busy1 !== 1'b0) begin miscompares++; $display("[TB] FAIL stall_end got %b expected 0", busy1); end
    endtask

    task automatic test_req_ignored;
        start_dec(KEY);
        for (int i = 0; i < 16; i++) begin
            vectors++; if (k1 !== K_TAB[15 - i]) begin miscompares++; $display("[TB] FAIL ignreq_k[%0d] got %h expected %h", i, k1, K_TAB[15 - i]); end
            if (i == 7) begin
                key1 = 64'hFFFFFFFFFFFFFFFF;
                req1 = 1'b1;
            end
            @(posedge clk); #1;
            req1 = 1'b0;
        end
        vectors++; if (busy1 !== 1'b0) begin miscompares++; $display("[TB] FAIL ignreq_end got %b expected 0", busy1); end
        key1 = KEY;
    endtask

    task automatic test_reset_mid_run;
        start_dec(KEY);
        repeat (9) begin
            @(posedge clk); #1;
        end
        vectors++; if (k1 !== K_TAB[6]) begin miscompares++; $display("[TB] FAIL midrst_pre got %h expected %h", k1, K_TAB[6]); end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++; if (busy1 !== 1'b0 || k_valid1 !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_async got %b/%b expected 0/0", busy1, k_valid1); end
        vectors++; if (k1 !== 48'h0) begin miscompares++; $display("[TB] FAIL midrst_k got %h expected 0", k1); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        vectors++; if (busy1 !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_idle got %b expected 0", busy1); end
        start_dec(KEY);
        vectors++; if (k1 !== K_TAB[15]) begin miscompares++; $display("[TB] FAIL midrst_first got %h expected %h", k1, K_TAB[15]); end
        @(posedge clk); #1;
        vectors++; if (k1 !== K_TAB[14]) begin miscompares++; $display("[TB] FAIL midrst_second got %h expected %h", k1, K_TAB[14]); end
        repeat (15) begin
            @(posedge clk); #1;
        end
        vectors++; if (busy1 !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_end got %b expected 0", busy1); end
    endtask

    task automatic test_back_to_back;
        start_enc(KEY);
        repeat (16) begin
            @(posedge clk); #1;
        end
        vectors++; if (busy0 !== 1'b0 || k_valid0 !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_gap got %b/%b expected 0/0", busy0, k_valid0); end
        req0 = 1'b1;
        @(posedge clk); #1;
        req0 = 1'b0;
        vectors++; if (busy0 !== 1'b1 || k0 !== K_TAB[0]) begin miscompares++; $display("[TB] FAIL b2b_first got %b/%h expected 1/%h", busy0, k0, K_TAB[0]); end
        @(posedge clk); #1;
        vectors++; if (k0 !== K_TAB[1]) begin miscompares++; $display("[TB] FAIL b2b_second got %h expected %h", k0, K_TAB[1]); end
        repeat (15) begin
            @(posedge clk); #1;
        end
        vectors++; if (busy0 !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_end got %b expected 0", busy0); end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset;
        test_decrypt_order;
        test_encrypt_order;
        test_stall;
        test_req_ignored;
        test_reset_mid_run;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
